lcd_frame_writer: RTL and testbench



---
 rtl/lcd_frame_writer.sv | 188 ++++++++++++++++++
 tb/tb_lcd_frame_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_writer.sv
// KS0108-style 128x64 LCD writer: power-up init, then streams a 1024-byte frame from a 1-cycle-latency pixel source.
// Optional continuous redraw when LCD_CONT_REFRESH_EN is defined.
module lcd_frame_writer #(
    parameter int RST_CYC = 16,
    parameter int EN_HIGH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       pix_rd_en,
    output logic [9:0] pix_addr,
    input  logic [7:0] pix_data,
    output logic       busy,
    output logic       frame_done,
    output logic       lcd_rst_n,
    output logic [1:0] lcd_cs,
    output logic       lcd_di,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);
    localparam int PW = $clog2(EN_HIGH + 2);
    localparam int RW = $clog2(RST_CYC + 1);

    typedef enum logic [2:0] {
        S_RST_HOLD, S_INIT, S_IDLE, S_SET_PAGE, S_SET_COL, S_FETCH, S_WRITE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    step_q, step_d;
    logic [2:0]    page_q, page_d;
    logic          half_q, half_d;
    logic [5:0]    col_q, col_d;
    logic [9:0]    addr_q, addr_d;
    logic [1:0]    cs_q, cs_d;
    logic          di_q, di_d;
    logic [7:0]    data_q, data_d;

    logic       tx_active, tx_phase0, tx_last;
    logic [1:0] tx_cs;
    logic       tx_di;
    logic [7:0] tx_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RST_HOLD;
            phase_q <= '0;
            rcnt_q  <= '0;
            step_q  <= '0;
            page_q  <= '0;
            half_q  <= 1'b0;
            col_q   <= '0;
            addr_q  <= '0;
            cs_q    <= '0;
            di_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rcnt_q  <= rcnt_d;
            step_q  <= step_d;
            page_q  <= page_d;
            half_q  <= half_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            di_q    <= di_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rcnt_d  = rcnt_q;
        step_d  = step_q;
        page_d  = page_q;
        half_d  = half_q;
        col_d   = col_q;
        addr_d  = addr_q;
        cs_d    = cs_q;
        di_d    = di_q;
        data_d  = data_q;

        tx_active = (state_q == S_INIT) || (state_q == S_SET_PAGE) ||
                    (state_q == S_SET_COL) || (state_q == S_WRITE);
        tx_phase0 = tx_active && (phase_q == '0);
        tx_last   = tx_active && (phase_q == PW'(EN_HIGH + 1));
        tx_cs     = half_q ? 2'b10 : 2'b01;
        tx_di     = (state_q == S_WRITE);
        tx_byte   = 8'h00;
        case (state_q)
            S_INIT: begin
                tx_cs   = step_q[1] ? 2'b10 : 2'b01;
                tx_byte = step_q[0] ? 8'hC0 : 8'h3F;
            end
            S_SET_PAGE: tx_byte = 8'hB8 | {5'd0, page_q};
            S_SET_COL:  tx_byte = 8'h40;
            S_WRITE:    tx_byte = pix_data;
            default:    tx_byte = 8'h00;
        endcase

        if (tx_active) phase_d = tx_last ? '0 : phase_q + 1'b1;
        // Bus fields are only launched in phase 0; the held copy covers the rest of the TX.
        if (tx_phase0) begin
            cs_d   = tx_cs;
            di_d   = tx_di;
            data_d = tx_byte;
        end

        case (state_q)
            S_RST_HOLD: begin
                if (rcnt_q == RW'(RST_CYC - 1)) state_d = S_INIT;
                else                            rcnt_d  = rcnt_q + 1'b1;
            end
            S_INIT: begin
                if (tx_last) begin
                    step_d = step_q + 1'b1;
`ifdef LCD_CONT_REFRESH_EN
                    if (step_q == 2'd3) state_d = S_SET_PAGE;
`else
                    if (step_q == 2'd3) state_d = S_IDLE;
`endif
                end
            end
            S_IDLE: begin
                if (start) begin
                    state_d = S_SET_PAGE;
                    page_d  = '0;
                    half_d  = 1'b0;
                end
            end
            S_SET_PAGE: if (tx_last) state_d = S_SET_COL;
            S_SET_COL: begin
                if (tx_last) begin
                    col_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                addr_d  = {page_q, half_q, col_q};
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (tx_last) begin
                    if (col_q != 6'd63) begin
                        col_d   = col_q + 1'b1;
                        state_d = S_FETCH;
                    end else if (!half_q) begin
                        half_d  = 1'b1;
                        state_d = S_SET_PAGE;
                    end else if (page_q != 3'd7) begin
                        page_d  = page_q + 1'b1;
                        half_d  = 1'b0;
                        state_d = S_SET_PAGE;
                    end else begin
                        page_d  = '0;
                        half_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
`ifdef LCD_CONT_REFRESH_EN
                state_d = S_SET_PAGE;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_RST_HOLD;
        endcase

        if (state_d == S_IDLE) cs_d = '0;
    end

    assign lcd_rw     = 1'b0;
    assign lcd_rst_n  = (state_q != S_RST_HOLD);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign pix_rd_en  = (state_q == S_FETCH);
    assign pix_addr   = (state_q == S_FETCH) ? {page_q, half_q, col_q} : addr_q;
    assign lcd_en     = tx_active && (phase_q != '0) && !tx_last;
    assign lcd_cs     = tx_phase0 ? tx_cs   : cs_q;
    assign lcd_di     = tx_phase0 ? tx_di   : di_q;
    assign lcd_data   = tx_phase0 ? tx_byte : data_q;
endmodule

// File: tb/tb_lcd_frame_writer.sv
// Self-checking bench for lcd_frame_writer: bus-log monitor, pixel ROM responder and frame-level reference model.
module tb_lcd_frame_writer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pix_rd_en;
    logic [9:0] pix_addr;
    logic [7:0] pix_data = 8'h00;
    logic       busy, frame_done, lcd_rst_n, lcd_di, lcd_rw, lcd_en;
    logic [1:0] lcd_cs;
    logic [7:0] lcd_data;

    lcd_frame_writer #(.RST_CYC(16), .EN_HIGH(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_data(pix_data),
        .busy(busy), .frame_done(frame_done), .lcd_rst_n(lcd_rst_n),
        .lcd_cs(lcd_cs), .lcd_di(lcd_di), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [7:0]  mem [1024];
    logic [10:0] txq [$];
    int data_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pixel source: data valid the cycle after the read strobe, garbage afterwards.
    initial forever begin
        @(negedge clk);
        if (pix_rd_en && !rst) begin
            logic [9:0] a;
            a = pix_addr;
            @(posedge clk);
            #1 pix_data = mem[a];
            @(posedge clk);
            #1 pix_data = 8'($urandom);
        end
    end

    // Bus monitor: logs each transaction at the en falling edge and checks strobe width and stability.
    initial begin
        logic        prev_en;
        int          hi;
        logic [10:0] pre, lat, cur;
        prev_en = 1'b0; hi = 0; pre = '0; lat = '0;
        forever begin
            @(negedge clk);
            cur = {lcd_cs, lcd_di, lcd_data};
            if (rst) begin
                prev_en = 1'b0;
                hi = 0;
            end else begin
                if (lcd_en && !prev_en) begin
                    check("setup_stable", cur, pre);
                    lat = cur;
                    hi = 1;
                end else if (lcd_en) begin
                    hi++;
                    if (cur !== lat) check("en_high_stable", cur, lat);
                end else if (prev_en) begin
                    check("en_high_cycles", hi, 2);
                    check("hold_stable", cur, lat);
                    txq.push_back(cur);
                    if (cur[8]) data_cnt++;
                end
                if (!lcd_en) pre = cur;
                if (lcd_rw !== 1'b0) check("lcd_rw", lcd_rw, 0);
                if (frame_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_en = lcd_en;
            end
        end
    end

    typedef struct { string name; logic [31:0] exp; } rv_t;
    typedef struct { logic [1:0] cs; logic di; logic [7:0] data; } tx_t;
    typedef struct { int pat; int start_at; int rst_at; int exp_done; int exp_data; } scen_t;
    rv_t   rv_tab [10];
    tx_t   init_tab [4];
    scen_t scen_tab [5];

    function automatic logic [31:0] out_val(input int i);
        case (i)
            0: return 32'(lcd_rst_n);
            1: return 32'(lcd_cs);
            2: return 32'(lcd_di);
            3: return 32'(lcd_rw);
            4: return 32'(lcd_en);
            5: return 32'(lcd_data);
            6: return 32'(pix_rd_en);
            7: return 32'(pix_addr);
            8: return 32'(frame_done);
            default: return 32'(busy);
        endcase
    endfunction

    task automatic check_reset_values();
        for (int i = 0; i < 10; i++) check(rv_tab[i].name, out_val(i), rv_tab[i].exp);
    endtask

    task automatic do_init();
        int cnt;
        bit ok;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        txq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (lcd_rst_n) begin ok = 1; break; end
            cnt++;
        end
        if (!ok) timeout("lcd_rst_n_release");
        check("rst_hold_cycles", cnt, 16);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) timeout("init_busy_fall");
        check("init_tx_count", txq.size(), 4);
        for (int i = 0; i < 4 && i < txq.size(); i++)
            check($sformatf("init_tx%0d", i), 32'(txq[i]),
                  32'({init_tab[i].cs, init_tab[i].di, init_tab[i].data}));
        check("idle_cs", lcd_cs, 0);
    endtask

    task automatic run_scen(input scen_t s);
        logic [10:0] exp [$];
        int  start_cyc, nbad, first_bad;
        bit  ok, pulsed, did_rst;
        logic [1:0] cs;
        for (int i = 0; i < 1024; i++)
            mem[i] = (s.pat == 0) ? 8'(i) : 8'($urandom);
        txq.delete();
        data_cnt = 0;
        done_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        ok = 0; pulsed = 0; did_rst = 0;
        for (int k = 0; k < 8000; k++) begin
            @(negedge clk);
            if (s.start_at >= 0 && !pulsed && data_cnt >= s.start_at) begin
                pulsed = 1;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (s.rst_at >= 0 && data_cnt >= s.rst_at) begin did_rst = 1; ok = 1; break; end
            if (done_cnt > 0 && !busy) begin ok = 1; break; end
        end
        if (!ok) timeout("frame_end");
        if (did_rst) begin
            #1 rst = 1'b1;
            #1 check_reset_values();
            check("data_at_reset", data_cnt, s.exp_data);
            do_init();
            check("done_after_reset", done_cnt, s.exp_done);
            return;
        end
        check("frame_done_pulses", done_cnt, s.exp_done);
        check("frame_done_latency", done_cyc - start_cyc, 5249);
        check("data_tx_count", data_cnt, s.exp_data);
        check("total_tx_count", txq.size(), 1056);
        for (int p = 0; p < 8; p++)
            for (int h = 0; h < 2; h++) begin
                cs = (h == 1) ? 2'b10 : 2'b01;
                exp.push_back({cs, 1'b0, 8'hB8 + 8'(p)});
                exp.push_back({cs, 1'b0, 8'h40});
                for (int c = 0; c < 64; c++)
                    exp.push_back({cs, 1'b1, mem[p * 128 + h * 64 + c]});
            end
        nbad = 0;
        first_bad = -1;
        for (int i = 0; i < exp.size(); i++)
            if (i >= txq.size() || txq[i] !== exp[i]) begin
                nbad++;
                if (first_bad < 0) first_bad = i;
            end
        if (first_bad >= 0) $display("first differing bus entry index %0d", first_bad);
        check("bus_log_diffs", nbad, 0);
        if (txq.size() >= 135) begin
            check("first_tx", 32'(txq[0]), 32'({2'b01, 1'b0, 8'hB8}));
            check("page1_cmd", 32'(txq[132]), 32'({2'b01, 1'b0, 8'hB9}));
            check("page1_col", 32'(txq[133]), 32'({2'b01, 1'b0, 8'h40}));
            check("page1_data0", 32'(txq[134]), 32'({2'b01, 1'b1, mem[128]}));
        end
        repeat (20) @(negedge clk);
        check("idle_after_frame", busy, 0);
        check("no_retrigger_data", data_cnt, s.exp_data);
        check("no_retrigger_done", done_cnt, s.exp_done);
    endtask

    initial begin
        rv_tab[0] = '{"rst_lcd_rst_n", 0};
        rv_tab[1] = '{"rst_lcd_cs", 0};
        rv_tab[2] = '{"rst_lcd_di", 0};
        rv_tab[3] = '{"rst_lcd_rw", 0};
        rv_tab[4] = '{"rst_lcd_en", 0};
        rv_tab[5] = '{"rst_lcd_data", 0};
        rv_tab[6] = '{"rst_pix_rd_en", 0};
        rv_tab[7] = '{"rst_pix_addr", 0};
        rv_tab[8] = '{"rst_frame_done", 0};
        rv_tab[9] = '{"rst_busy", 1};
        init_tab[0] = '{2'b01, 1'b0, 8'h3F};
        init_tab[1] = '{2'b01, 1'b0, 8'hC0};
        init_tab[2] = '{2'b10, 1'b0, 8'h3F};
        init_tab[3] = '{2'b10, 1'b0, 8'hC0};
        scen_tab[0] = '{0, -1,  -1, 1, 1024};
        scen_tab[1] = '{1, -1,  -1, 1, 1024};
        scen_tab[2] = '{1, 300, -1, 1, 1024};
        scen_tab[3] = '{1, -1, 500, 0, 500};
        scen_tab[4] = '{1, -1,  -1, 1, 1024};

        rst = 1'b1;
        do_init();
        for (int i = 0; i < 5; i++) run_scen(scen_tab[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
